// File: rtl/pwm_deadtime_gen.sv
// Center-aligned single-leg PWM with complementary dead-time gate drive,
// a period-start strobe and a mid-low-window ADC sample strobe.
module pwm_deadtime_gen #(
    parameter int unsigned       CNT_W  = 11,
    parameter logic [CNT_W-1:0]  PERIOD = 11'd1024,
    parameter logic [7:0]        DEAD   = 8'd10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_vld,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_start,
    output logic             sample_trig
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StOff,
        StHOn,
        StLOn,
        StDt
    } gate_state_e;

    logic [CNT_W-1:0] cnt_q;
    logic             dir_up_q;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] duty_act_q;
    logic [CNT_W-1:0] duty_clamped;
    logic             raw;
    gate_state_e      state_q;
    logic [7:0]       dead_q;
    logic             dt_side_q;

    always_comb begin
        duty_clamped = (shadow_q > PERIOD) ? PERIOD : shadow_q;
        raw          = (duty_act_q >= PERIOD) ? 1'b1 : (cnt_q < duty_act_q);
    end

    // Triangle carrier: 0..PERIOD up, PERIOD-1..1 down, then back to 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q    <= '0;
            dir_up_q <= 1'b1;
        end else if (dir_up_q) begin
            if (cnt_q == PERIOD) begin
                cnt_q    <= PERIOD - CNT_ONE;
                dir_up_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end else begin
            if (cnt_q <= CNT_ONE) begin
                cnt_q    <= '0;
                dir_up_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    // The transfer reads the pre-update shadow, so a coincident load waits a period.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_q   <= '0;
            duty_act_q <= '0;
        end else begin
            if (duty_vld) begin
                shadow_q <= duty;
            end
            if (cnt_q == '0) begin
                duty_act_q <= duty_clamped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            period_start <= 1'b0;
            sample_trig  <= 1'b0;
        end else begin
            period_start <= (cnt_q == '0) && dir_up_q;
            sample_trig  <= (cnt_q == PERIOD) && (duty_act_q < PERIOD) && en;
        end
    end

    // dt_side_q is the side the dead-time window is heading towards; a raw
    // change while waiting restarts the full dead time.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StOff;
            dead_q    <= DEAD;
            dt_side_q <= 1'b0;
            pwm_h     <= 1'b0;
            pwm_l     <= 1'b0;
        end else if (!en) begin
            state_q <= StOff;
            dead_q  <= DEAD;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_q   <= StDt;
                    dead_q    <= DEAD;
                    dt_side_q <= raw;
                    pwm_h     <= 1'b0;
                    pwm_l     <= 1'b0;
                end
                StHOn: begin
                    pwm_l <= 1'b0;
                    if (!raw) begin
                        state_q   <= StDt;
                        dead_q    <= DEAD;
                        dt_side_q <= 1'b0;
                        pwm_h     <= 1'b0;
                    end else begin
                        pwm_h <= 1'b1;
                    end
                end
                StLOn: begin
                    pwm_h <= 1'b0;
                    if (raw) begin
                        state_q   <= StDt;
                        dead_q    <= DEAD;
                        dt_side_q <= 1'b1;
                        pwm_l     <= 1'b0;
                    end else begin
                        pwm_l <= 1'b1;
                    end
                end
                StDt: begin
                    if (raw != dt_side_q) begin
                        dead_q    <= DEAD;
                        dt_side_q <= raw;
                        pwm_h     <= 1'b0;
                        pwm_l     <= 1'b0;
                    end else if (dead_q <= 8'd1) begin
                        // Last dead cycle: the gate register turns on next cycle.
                        state_q <= raw ? StHOn : StLOn;
                        dead_q  <= 8'd0;
                        pwm_h   <= raw;
                        pwm_l   <= !raw;
                    end else begin
                        dead_q <= dead_q - 8'd1;
                        pwm_h  <= 1'b0;
                        pwm_l  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StOff;
                    pwm_h   <= 1'b0;
                    pwm_l   <= 1'b0;
                end
            endcase
        end
    end

endmodule
